fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_RESET, 32'h0000_3000, first fetch address after reset.
REQ-002 Parameter IM_WORDS, 1024, instruction memory depth in words; legal fetch range is PC_RESET to PC_RESET+4*IM_WORDS-4.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; one clock, sampled on the rising edge of clk.
REQ-005 stall  in  1  hold PC and IF/ID register.
REQ-006 flush  in  1  replace IF/ID contents with a bubble.
REQ-007 npc_sel  in  2  next-PC source: 00 PC+4, 01 branch, 10 j/jal, 11 jr.
REQ-008 br_taken  in  1  branch condition from decode; only meaningful when npc_sel=01.
REQ-009 imm16  in  16  branch offset of the instruction in decode.
REQ-010 instr_index  in  26  jump field of the instruction in decode.
REQ-011 jr_target  in  32  register value for jr/jalr.
REQ-012 im_instr  in  32  word returned combinationally by instruction memory for address pc.
REQ-013 pc  out  32  current fetch address, driven to instruction memory address input.
REQ-014 d_instr  out  32  IF/ID instruction.
REQ-015 d_pc  out  32  IF/ID PC.
REQ-016 d_pc8  out  32  d_pc+8, link value for jal/jalr.
REQ-017 d_valid  out  1  IF/ID holds a real instruction.
REQ-018 fetch_fault  out  1  sticky flag: illegal fetch address seen.

Function
REQ-019 Redirect targets use decode-stage PC: branch = d_pc+4+(sext(imm16)<<2); jump = {d_pc[31:28], instr_index, 2'b00}; jr = jr_target.
REQ-020 next_pc = target when npc_sel=10 or 11, or npc_sel=01 with br_taken=1; otherwise pc+4.
REQ-021 All adds are 32-bit modulo 2^32; wrap-around is not trapped by the adder but caught by the range check.
REQ-022 Branch-delay-slot semantics: the word fetched in the redirect cycle still enters IF/ID; no automatic squash.
REQ-023 Normal cycle (stall=0, flush=0): pc <= next_pc; IF/ID <= {im_instr, pc, valid=1}.
REQ-024 stall=1: pc and IF/ID hold; redirect inputs ignored that cycle.
REQ-025 flush=1: IF/ID <= {0, pc, valid=0}; flush wins over stall for IF/ID; pc holds if stall=1, else advances per REQ-020.
REQ-026 Illegal fetch: pc outside legal range or pc[1:0]!=0; that cycle IF/ID loads bubble (instr 0, valid 0) instead of im_instr.
REQ-027 fetch_fault sets on the first clock edge where an illegal fetch would be loaded (REQ-026), stays 1 until reset; PC continues to update normally.
REQ-028 d_pc8 is combinational from d_pc, zero latency.
REQ-029 Latency: instruction at address A appears on d_instr one clock after pc=A, absent stall.

Reset
REQ-030 On reset=0 at a rising edge: pc=PC_RESET, d_instr=0, d_pc=0, d_valid=0, fetch_fault=0.
REQ-031 Reset overrides stall, flush and redirect; reset mid-redirect discards target.
REQ-032 First edge after reset released: IF/ID loads word at PC_RESET, pc=PC_RESET+4.

Structure
REQ-033 Shared package holds PC_RESET default, IM_WORDS default, npc_sel encodings (NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JR).
REQ-034 One combinational sub-module npc computes next_pc from pc, d_pc, npc_sel, br_taken, imm16, instr_index, jr_target; fetch_unit holds registers and range check.

Verification
REQ-035 Reset, then 3 free cycles -> pc 0x3000,0x3004,0x3008,0x300C; d_pc trails by one; d_valid=1 from cycle 1.
REQ-036 d_pc=0x3010, npc_sel=01, br_taken=1, imm16=0xFFFC -> next pc=0x3004; delay-slot word at 0x3014 in IF/ID with valid=1.
REQ-037 d_pc=0x3020, npc_sel=10, instr_index=0x0000C40 -> next pc=0x3100; d_pc8=0x3028.
REQ-038 stall=1 for 2 cycles with npc_sel=11, jr_target=0x3200 -> pc and d_instr frozen; on release, jr taken, pc=0x3200.
REQ-039 npc_sel=11, jr_target=0x3002 -> next cycle bubble loaded, fetch_fault=1, stays 1 through later legal fetches until reset=0.
REQ-040 flush=1 and stall=1 together at pc=0x3040 -> d_valid=0, d_instr=0, pc stays 0x3040.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset address, memory
// depth and next-PC source encodings.
package fetch_unit_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam int          IM_WORDS_DEFAULT = 1024;

   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'b00,
      NPC_BRANCH = 2'b01,
      NPC_JUMP   = 2'b10,
      NPC_JR     = 2'b11
   } npc_sel_t;

   // Branch displacement: sign-extended word offset turned into a byte offset.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Next-PC selection. Redirect targets are formed from the decode-stage PC,
// the sequential path from the fetch PC.
module fetch_unit_npc
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] d_pc,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc
);

   logic [31:0] seq_pc;
   logic [31:0] br_tgt;
   logic [31:0] jmp_tgt;

   // All sums wrap modulo 2^32; out-of-range results are caught at fetch.
   assign seq_pc  = pc + 32'd4;
   assign br_tgt  = d_pc + 32'd4 + branch_offset(imm16);
   assign jmp_tgt = {d_pc[31:28], instr_index, 2'b00};

   always_comb begin
      next_pc = seq_pc;
      case (npc_sel)
         NPC_BRANCH: if (br_taken) next_pc = br_tgt;
         NPC_JUMP:   next_pc = jmp_tgt;
         NPC_JR:     next_pc = jr_target;
         default:    next_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch
// address range check and sticky fetch fault flag.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
   parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic [1:0]  npc_sel,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] instr_index,
   input  logic [31:0] jr_target,
   input  logic [31:0] im_instr,
   output logic [31:0] pc,
   output logic [31:0] d_instr,
   output logic [31:0] d_pc,
   output logic [31:0] d_pc8,
   output logic        d_valid,
   output logic        fetch_fault
);

   localparam logic [31:0] PC_LAST = PC_RESET + 32'(IM_WORDS * 4) - 32'd4;

   logic [31:0] next_pc;
   logic        fetch_ok;
   logic        load_fetch;

   fetch_unit_npc u_npc (
      .pc          (pc),
      .d_pc        (d_pc),
      .npc_sel     (npc_sel),
      .br_taken    (br_taken),
      .imm16       (imm16),
      .instr_index (instr_index),
      .jr_target   (jr_target),
      .next_pc     (next_pc)
   );

   assign fetch_ok   = (pc >= PC_RESET) && (pc <= PC_LAST) && (pc[1:0] == 2'b00);
   // IF/ID takes the fetched word only on an unstalled, unflushed cycle.
   assign load_fetch = !stall && !flush;
   assign d_pc8      = d_pc + 32'd8;

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc          <= PC_RESET;
         d_instr     <= 32'd0;
         d_pc        <= 32'd0;
         d_valid     <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         if (!stall) begin
            pc <= next_pc;
         end

         if (flush) begin
            d_instr <= 32'd0;
            d_pc    <= pc;
            d_valid <= 1'b0;
         end else if (!stall) begin
            d_instr <= fetch_ok ? im_instr : 32'd0;
            d_pc    <= pc;
            d_valid <= fetch_ok;
         end

         if (load_fetch && !fetch_ok) begin
            fetch_fault <= 1'b1;
         end
      end
   end

endmodule
